// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//   Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with
//   a valid/ready handshake. A main register plus one skid entry give full
//   throughput under backpressure while keeping in_ready a plain flop.
//   Flush squashes both held entries; the control field of a squashed or
//   empty entry reads as 0 so a bubble never writes a register or memory.
//
// Parameters
//   DATA_W  data payload width (pc, alu result, store data, imm, ...)
//   CTRL_W  control payload width (reg_write, mem_write, rd, ...)
//   CNT_W   stall-cycle counter width
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   flush      in   squash all held entries
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept (registered)
//   in_ctrl    in   upstream control bits
//   in_data    in   upstream data bits
//   out_valid  out  downstream payload valid
//   out_ready  in   downstream accepts (0 = stall)
//   out_ctrl   out  control bits to next stage
//   out_data   out  data bits to next stage
//   stall_cnt  out  saturating count of cycles with out_valid=1, out_ready=0
//
// Configuration
//   PIPE_STALL_CNT_EN  when defined, builds the stall counter; otherwise
//                      stall_cnt is tied to 0.
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   // State encoding is {main_v, skid_v}; 2'b01 is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b10,
      ST_SKID  = 2'b11
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CTRL_W-1:0] main_ctrl_r, main_ctrl_nxt_s;
   logic [DATA_W-1:0] main_data_r, main_data_nxt_s;
   logic [CTRL_W-1:0] skid_ctrl_r, skid_ctrl_nxt_s;
   logic [DATA_W-1:0] skid_data_r, skid_data_nxt_s;
   logic              in_ready_r;
   logic              main_v_s;
   logic              accept_s;
   logic              send_s;

   assign main_v_s = (state_r == ST_FULL) || (state_r == ST_SKID);
   assign accept_s = in_valid && in_ready_r;
   assign send_s   = main_v_s && out_ready;

   assign in_ready  = in_ready_r;
   assign out_valid = main_v_s;
   assign out_ctrl  = main_ctrl_r;
   assign out_data  = main_data_r;

   // Next-state and next-payload selection for the main/skid pair.
   always_comb begin
      state_nxt_s     = state_r;
      main_ctrl_nxt_s = main_ctrl_r;
      main_data_nxt_s = main_data_r;
      skid_ctrl_nxt_s = skid_ctrl_r;
      skid_data_nxt_s = skid_data_r;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               state_nxt_s     = ST_FULL;
               main_ctrl_nxt_s = in_ctrl;
               main_data_nxt_s = in_data;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (accept_s && send_s) begin
               main_ctrl_nxt_s = in_ctrl;
               main_data_nxt_s = in_data;
            end else if (accept_s) begin
               state_nxt_s     = ST_SKID;
               skid_ctrl_nxt_s = in_ctrl;
               skid_data_nxt_s = in_data;
            end else if (send_s) begin
               // Draining to empty: ctrl becomes a bubble, data keeps its value.
               state_nxt_s     = ST_EMPTY;
               main_ctrl_nxt_s = {CTRL_W{1'b0}};
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         ST_SKID: begin
            if (send_s) begin
               state_nxt_s     = ST_FULL;
               main_ctrl_nxt_s = skid_ctrl_r;
               main_data_nxt_s = skid_data_r;
               skid_ctrl_nxt_s = {CTRL_W{1'b0}};
               skid_data_nxt_s = {DATA_W{1'b0}};
            end else begin
               state_nxt_s = ST_SKID;
            end
         end
         default: begin
            state_nxt_s     = ST_EMPTY;
            main_ctrl_nxt_s = {CTRL_W{1'b0}};
            main_data_nxt_s = {DATA_W{1'b0}};
            skid_ctrl_nxt_s = {CTRL_W{1'b0}};
            skid_data_nxt_s = {DATA_W{1'b0}};
         end
      endcase
   end

   // State and payload registers; reset beats flush beats capture.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         state_r     <= ST_EMPTY;
         main_ctrl_r <= {CTRL_W{1'b0}};
         main_data_r <= {DATA_W{1'b0}};
         skid_ctrl_r <= {CTRL_W{1'b0}};
         skid_data_r <= {DATA_W{1'b0}};
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         main_ctrl_r <= main_ctrl_nxt_s;
         main_data_r <= main_data_nxt_s;
         skid_ctrl_r <= skid_ctrl_nxt_s;
         skid_data_r <= skid_data_nxt_s;
         // in_ready is the registered complement of the next skid_v.
         in_ready_r  <= (state_nxt_s != ST_SKID);
      end
   end

`ifdef PIPE_STALL_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   logic [CNT_W-1:0] stall_cnt_r;

   // Saturating stall counter; flush intentionally does not clear it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (main_v_s && !out_ready && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`else
   assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
